// File: rtl/binop_share_arb_pkg.sv
// Shared types, defaults and helpers for the binop_share_arb shared-adder arbiter.
package binop_share_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  // Round-robin successor of idx among nreq requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    return ((idx + 32'd1) >= nreq) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/binop_share_arb_if.sv
// Requester/consumer bundle for binop_share_arb; req_lock exists only with BINOP_SHARE_ARB_LOCK_EN.
interface binop_share_arb_if #(
  parameter int unsigned NREQ = binop_share_arb_pkg::NREQ_DEF,
  parameter int unsigned W    = binop_share_arb_pkg::W_DEF,
  parameter int unsigned IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              rsp_ready;
`ifdef BINOP_SHARE_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
`ifdef BINOP_SHARE_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
`ifdef BINOP_SHARE_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/binop_share_arb_rr_pick.sv
// Rotating-priority encoder: first asserted req at or above ptr (with wrap), gated by enable.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant_c,
  output logic [IDW-1:0]  o_idx_c
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic           w_found;
  logic [IDW:0]   w_pos;
  logic [IDW-1:0] w_j;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    w_j       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_pos >= NREQ_W) w_pos = w_pos - NREQ_W;
      w_j = w_pos[IDW-1:0];
      if (i_en && !w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant_c[w_j] = 1'b1;
        o_idx_c      = w_j;
      end
    end
  end

endmodule

// File: rtl/binop_share_arb.sv
// Shares one W-bit adder among NREQ requesters, round-robin, single-entry registered response slot.
// Optional requester lock enabled by BINOP_SHARE_ARB_LOCK_EN.
module binop_share_arb
  import binop_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input logic              clk,
  input logic              rst_n,
  binop_share_arb_if.slave bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_sum;
  logic            r_rsp_carry;
  logic [IDW-1:0]  r_ptr;

  logic            w_slot_free;
  logic            w_en;
  logic            w_accept;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W:0]      w_sum;

  assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
  assign w_en        = rst_n && w_slot_free;

`ifdef BINOP_SHARE_ARB_LOCK_EN
  logic            r_lock_act;
  logic [IDW-1:0]  r_lock_own;

  // While locked, only the owner is eligible.
  assign w_req = r_lock_act ? (bus.req_valid & (NREQ'(1) << r_lock_own)) : bus.req_valid;
`else
  assign w_req = bus.req_valid;
`endif

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .i_en      (w_en),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx)
  );

  assign w_accept      = |w_grant;
  assign bus.req_ready = w_grant;
  assign w_ptr_nxt     = IDW'(rr_next(32'(w_idx), NREQ));

  // One-hot operand mux into the shared adder.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a = w_a | bus.req_a[i*W +: W];
        w_b = w_b | bus.req_b[i*W +: W];
      end
    end
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = FULL;
      FULL: begin
        if (w_accept)           w_state_nxt = FULL;
        else if (bus.rsp_ready) w_state_nxt = IDLE;
        else                    w_state_nxt = STALL;
      end
      STALL:   if (bus.rsp_ready) w_state_nxt = w_accept ? FULL : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_rsp_id    <= w_idx;
        r_rsp_sum   <= w_sum[W-1:0];
        r_rsp_carry <= w_sum[W];
      end
    end
  end

`ifdef BINOP_SHARE_ARB_LOCK_EN
  // A locking accept freezes ptr; the unlocking accept advances it as usual.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_lock_act <= 1'b0;
      r_lock_own <= '0;
    end else if (w_accept) begin
      if (bus.req_lock[w_idx]) begin
        r_lock_act <= 1'b1;
        r_lock_own <= w_idx;
      end else begin
        r_lock_act <= 1'b0;
        r_ptr      <= w_ptr_nxt;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= '0;
    else if (w_accept) r_ptr <= w_ptr_nxt;
  end
`endif

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_carry = r_rsp_carry;

endmodule
